// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch unit with a 2-entry {word, pc} queue.
//
// Purpose
//   Issues word fetches to instruction memory. At most one request is in
//   flight at a time. Returned words are buffered in a 2-entry FIFO in front
//   of decode. A redirect flushes the queue. If a redirect arrives while a
//   request is still waiting for its ack, that request is allowed to finish
//   and its data is dropped (DRAIN state).
//
// Ports
//   clk, reset        : single clock; synchronous active-high reset
//   imem_req/addr     : fetch request and its word address (registered)
//   imem_ack/rdata    : memory response; data valid when imem_ack=1
//   redirect/_pc      : branch/jump taken; flush and refetch from redirect_pc
//   instr_valid/ready : decode handshake on the queue head
//   instr, instr_pc   : head word and its PC (0 when the queue is empty)
//   pc_plus4          : instr_pc + 4 (mod 2^32)
//   fetch_misalign    : misaligned-redirect trap flag
//
// Configuration
//   FETCH_MISALIGN_TRAP_EN : when defined, a redirect target with non-zero
//   low bits flushes the queue, sets fetch_misalign and parks the unit in
//   TRAP until an aligned redirect arrives. When undefined, the low two
//   bits of redirect_pc are forced to zero and fetch_misalign is tied 0.

module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_misalign
);

`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {FETCH = 2'd0, DRAIN = 2'd1, TRAP = 2'd2} state_t;
`else
  typedef enum logic [1:0] {FETCH = 2'd0, DRAIN = 2'd1} state_t;
`endif

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;          // address of the current/next request
  logic [31:0] target_q, target_d;  // redirect target latched while draining
  logic        req_q, req_d;        // request outstanding
  logic        misalign_q, misalign_d;
  logic [1:0]  count_q, count_d;
  logic        head_q, head_d;

  logic [31:0] fifo_word_q [2];
  logic [31:0] fifo_pc_q   [2];

  logic        ack_v;     // ack that belongs to a real request
  logic        deq;
  logic        enq;
  logic        flush;
  logic        pending;   // request stays outstanding past this edge
  logic        wr_slot;
  logic [31:0] rpc;       // effective redirect target
  logic        rpc_bad;   // redirect target is misaligned (trap build only)

`ifdef FETCH_MISALIGN_TRAP_EN
  assign rpc     = redirect_pc;
  assign rpc_bad = (redirect_pc[1:0] != 2'b00);
`else
  logic unused_rpc_low;
  assign rpc            = {redirect_pc[31:2], 2'b00};
  assign rpc_bad        = 1'b0;
  assign unused_rpc_low = ^redirect_pc[1:0];
`endif

  // An ack while no request is outstanding (e.g. one abandoned by reset)
  // is ignored.
  assign ack_v   = imem_ack & req_q;
  assign pending = req_q & ~ack_v;
  assign deq     = instr_valid & instr_ready;
  assign wr_slot = head_q ^ count_q[0];

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    target_d   = target_q;
    misalign_d = misalign_q;
    enq        = 1'b0;
    flush      = 1'b0;

    if (redirect) begin
      // Redirect beats any same-cycle ack or dequeue.
      flush = 1'b1;
      if (rpc_bad) begin
`ifdef FETCH_MISALIGN_TRAP_EN
        state_d    = TRAP;
        misalign_d = 1'b1;
`endif
      end else begin
        misalign_d = 1'b0;
        if (pending) begin
          // Old request must finish first; remember where to go afterwards.
          state_d  = DRAIN;
          target_d = rpc;
        end else begin
          state_d = FETCH;
          pc_d    = rpc;
        end
      end
    end else begin
      unique case (state_q)
        FETCH: begin
          if (ack_v) begin
            enq  = 1'b1;
            pc_d = pc_q + 32'd4;
          end
        end
        DRAIN: begin
          // Stale data is dropped; resume at the latched target.
          if (ack_v) begin
            state_d = FETCH;
            pc_d    = target_q;
          end
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        TRAP: begin
          // Parked: acks of a request issued before the trap are dropped.
        end
`endif
        default: state_d = FETCH;
      endcase
    end

    if (flush) begin
      count_d = 2'd0;
      head_d  = 1'b0;
    end else begin
      count_d = count_q + {1'b0, enq} - {1'b0, deq};
      head_d  = head_q ^ deq;
    end

    // Hold an unanswered request; otherwise issue only in FETCH with room.
    if (pending) begin
      req_d = 1'b1;
    end else if (state_d == FETCH) begin
      req_d = (count_d < 2'd2);
    end else begin
      req_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      target_q   <= RESET_PC;
      req_q      <= 1'b0;
      misalign_q <= 1'b0;
      count_q    <= 2'd0;
      head_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      target_q   <= target_d;
      req_q      <= req_d;
      misalign_q <= misalign_d;
      count_q    <= count_d;
      head_q     <= head_d;
    end
  end

  // Queue storage; contents are only visible through count_q, so no reset.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slot
      always_ff @(posedge clk) begin
        if (enq && !flush && (wr_slot == gi[0])) begin
          fifo_word_q[gi] <= imem_rdata;
          fifo_pc_q[gi]   <= pc_q;
        end
      end
    end
  endgenerate

  assign imem_req       = req_q;
  assign imem_addr      = pc_q;
  assign instr_valid    = (count_q != 2'd0);
  assign instr          = instr_valid ? fifo_word_q[head_q] : 32'd0;
  assign instr_pc       = instr_valid ? fifo_pc_q[head_q]   : 32'd0;
  assign pc_plus4       = instr_pc + 32'd4;
  assign fetch_misalign = misalign_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed testbench for instr_fetch. Memory returns ~addr as the word.
module tb_instr_fetch;
  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] pc_plus4;
  logic        fetch_misalign;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  always_comb imem_rdata = ~imem_addr;

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc), .pc_plus4(pc_plus4),
    .fetch_misalign(fetch_misalign)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic ack, input logic rdy);
    reset = 1'b1; imem_ack = ack; instr_ready = rdy;
    redirect = 1'b0; redirect_pc = 32'd0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    // Reset state, with a stray ack held high during and after reset.
    do_reset(1'b1, 1'b1);
    chk("rst_req",   {31'd0, imem_req},       32'd0);
    chk("rst_addr",  imem_addr,               32'd0);
    chk("rst_valid", {31'd0, instr_valid},    32'd0);
    chk("rst_instr", instr,                   32'd0);
    chk("rst_pc",    instr_pc,                32'd0);
    chk("rst_pc4",   pc_plus4,                32'd4);
    chk("rst_mis",   {31'd0, fetch_misalign}, 32'd0);

    // Zero-wait streaming: addresses 0,4,8,...; valid from cycle 2.
    tick();
    chk("s1_req",   {31'd0, imem_req},    32'd1);
    chk("s1_addr",  imem_addr,            32'd0);
    chk("s1_valid", {31'd0, instr_valid}, 32'd0);
    for (int k = 2; k <= 6; k++) begin
      tick();
      chk("s_addr",  imem_addr,            32'(4 * (k - 1)));
      chk("s_valid", {31'd0, instr_valid}, 32'd1);
      chk("s_pc",    instr_pc,             32'(4 * (k - 2)));
      chk("s_word",  instr,                ~32'(4 * (k - 2)));
    end

    // Back-pressure: exactly two enqueues, then no requests.
    do_reset(1'b1, 1'b0);
    tick();
    tick();
    tick();
    chk("bp_req3", {31'd0, imem_req}, 32'd0);
    tick();
    chk("bp_req4", {31'd0, imem_req}, 32'd0);
    chk("bp_head", instr_pc,          32'd0);
    instr_ready = 1'b1;
    tick();
    chk("bp_head2", instr_pc,          32'd4);
    chk("bp_req5",  {31'd0, imem_req}, 32'd1);
    chk("bp_addr5", imem_addr,         32'd8);
    tick();
    chk("bp_head3", instr_pc,  32'd8);
    chk("bp_addr6", imem_addr, 32'd12);

    // Redirect while request to 8 is stalled.
    do_reset(1'b1, 1'b1);
    tick();
    tick();
    tick();
    chk("dr_addr0", imem_addr, 32'd8);
    imem_ack = 1'b0; redirect = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    chk("dr_addr1",  imem_addr,            32'd8);
    chk("dr_req1",   {31'd0, imem_req},    32'd1);
    chk("dr_valid1", {31'd0, instr_valid}, 32'd0);
    tick();
    chk("dr_addr2", imem_addr, 32'd8);
    imem_ack = 1'b1;
    tick();
    chk("dr_addr3",  imem_addr,            32'h100);
    chk("dr_valid3", {31'd0, instr_valid}, 32'd0);
    tick();
    chk("dr_head", instr_pc, 32'h100);
    chk("dr_word", instr,    ~32'h100);

    // Redirect together with ack and dequeue.
    redirect = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect = 1'b0;
    chk("ra_valid", {31'd0, instr_valid}, 32'd0);
    chk("ra_addr",  imem_addr,            32'h40);
    tick();
    chk("ra_head", instr_pc, 32'h40);

    // Address wrap.
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    chk("wr_addr0", imem_addr, 32'hFFFF_FFFC);
    tick();
    chk("wr_addr1", imem_addr, 32'd0);
    chk("wr_head",  instr_pc,  32'hFFFF_FFFC);
    chk("wr_pc4",   pc_plus4,  32'd0);

    // Misaligned redirect.
    redirect = 1'b1; redirect_pc = 32'h102;
    tick();
    redirect = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("ma_mis",   {31'd0, fetch_misalign}, 32'd1);
    chk("ma_req",   {31'd0, imem_req},       32'd0);
    chk("ma_valid", {31'd0, instr_valid},    32'd0);
    tick();
    chk("ma_req2", {31'd0, imem_req}, 32'd0);
    redirect = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect = 1'b0;
    chk("ma_clr",  {31'd0, fetch_misalign}, 32'd0);
    chk("ma_addr", imem_addr,               32'h200);
    chk("ma_req3", {31'd0, imem_req},       32'd1);
`else
    chk("ma_addr", imem_addr,               32'h100);
    chk("ma_mis",  {31'd0, fetch_misalign}, 32'd0);
    chk("ma_req",  {31'd0, imem_req},       32'd1);
    tick();
    chk("ma_head", instr_pc, 32'h100);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: imem_req  output  1  fetch request to instruction memory.
REQ-005 SHALL have port: imem_addr  output  32  word address of the current request.
REQ-006 SHALL have port: imem_ack  input  1  memory returns data this cycle.
REQ-007 SHALL have port: imem_rdata  input  32  instruction word, valid when imem_ack=1.
REQ-008 SHALL have port: redirect  input  1  branch/jump taken; flush and refetch.
REQ-009 SHALL have port: redirect_pc  input  32  target PC, sampled when redirect=1.
REQ-010 SHALL have port: instr_valid  output  1  queue head holds a valid instruction.
REQ-011 SHALL have port: instr_ready  input  1  decode stage accepts queue head.
REQ-012 SHALL have port: instr  output  32  queue head word; bits [31:7] feed immediate extension, [6:0] feed the decoder.
REQ-013 SHALL have port: instr_pc  output  32  PC of queue head.
REQ-014 SHALL have port: pc_plus4  output  32  instr_pc + 4, modulo 2^32.
REQ-015 SHALL have port: fetch_misalign  output  1  misaligned redirect trap flag (REQ-034 only).

Function
REQ-016 SHALL hold a 2-entry FIFO of {word, pc}; instr/instr_pc show the head entry, or 0 when empty.
REQ-017 SHALL allow at most one outstanding request; while imem_req=1 and imem_ack=0, imem_req and imem_addr SHALL stay stable.
REQ-018 SHALL issue a request only when FIFO count plus in-flight count is below 2.
REQ-019 SHALL enqueue {imem_rdata, imem_addr} on the edge ending an imem_ack cycle; instr_valid SHALL rise the next cycle (1-cycle latency).
REQ-020 SHALL advance the fetch PC by 4 on each accepted ack and SHALL wrap from 32'hFFFF_FFFC to 0.
REQ-021 SHALL allow the next request in the cycle after an ack, giving 1 instruction/cycle with a zero-wait memory and instr_ready held high.
REQ-022 SHALL dequeue the head when instr_valid=1 and instr_ready=1; simultaneous enqueue and dequeue SHALL keep count unchanged.
REQ-023 SHALL have FSM states FETCH (requesting/idle for space), DRAIN (stale request outstanding), TRAP (REQ-034 only).
REQ-024 FETCH->FETCH on redirect with no outstanding request: flush FIFO, fetch PC := redirect_pc, new request next cycle.
REQ-025 FETCH->DRAIN on redirect while a request is outstanding without ack: flush FIFO, latch redirect_pc.
REQ-026 DRAIN: keep the old request until imem_ack, discard its data, then go to FETCH with fetch PC = latched target.
REQ-027 A redirect in the same cycle as imem_ack SHALL discard that data, flush, and stay in FETCH.
REQ-028 A redirect in DRAIN SHALL overwrite the latched target.
REQ-029 Redirect SHALL win over a same-cycle dequeue; instr_valid SHALL be 0 the next cycle.
REQ-030 Redirect in a cycle with FIFO full and no outstanding request SHALL flush, with a request next cycle.

Reset
REQ-031 On reset=1 at a clock edge: FIFO empty, in-flight cleared, state FETCH, fetch PC := RESET_PC, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, pc_plus4=4, fetch_misalign=0.
REQ-032 First imem_req SHALL assert in the first cycle after reset deasserts.
REQ-033 Reset mid-request SHALL abandon it; an imem_ack arriving after reset with no request issued SHALL be ignored.

Configuration
REQ-034 With FETCH_MISALIGN_TRAP_EN defined: redirect_pc[1:0]!=0 SHALL flush, set fetch_misalign=1 and enter TRAP. In TRAP there SHALL be no requests and instr_valid=0. The next aligned redirect SHALL clear fetch_misalign and resume (via DRAIN rules if needed).
REQ-035 Without FETCH_MISALIGN_TRAP_EN: redirect_pc[1:0] SHALL be forced to 2'b00, fetch_misalign SHALL be tied 0, and TRAP SHALL not exist.

Verification
REQ-036 Reset, RESET_PC=0, zero-wait memory, instr_ready=1 -> addresses 0,4,8,... on consecutive cycles; instr_valid from cycle 2; instr_pc tracks addresses.
REQ-037 instr_ready=0, memory acks immediately -> exactly 2 enqueues (pc 0,4), imem_req=0 thereafter; instr_ready=1 -> pc 0 then 4 delivered, fetching resumes at 8.
REQ-038 Request to 8 held 3 cycles without ack, redirect to 0x100 in cycle 1 -> imem_addr stays 8 until ack, data dropped, next request 0x100, first instr_pc=0x100.
REQ-039 Redirect to 0x40 in the same cycle as ack and dequeue -> instr_valid=0 next cycle, next imem_addr=0x40.
REQ-040 Fetch PC 0xFFFF_FFFC -> next request address 0, pc_plus4 for head 0xFFFF_FFFC equals 0.
REQ-041 Redirect to 0x102 -> with FETCH_MISALIGN_TRAP_EN: fetch_misalign=1, no requests until a redirect to 0x200 clears it; without the macro: next imem_addr=0x100.
